// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
// uart_rx_os16 : 16x oversampled UART receiver (8N1 / 8E1 / 8O1, LSB first)
// Revision 1.0 : initial release
// ============================================================================
module uart_rx_os16 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       baud_tick_x16_i,
    input  logic       rx_en_i,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] C_TICK_S0  = 4'd7;
    localparam logic [3:0] C_TICK_S1  = 4'd8;
    localparam logic [3:0] C_TICK_VOTE = 4'd9;
    localparam logic [3:0] C_TICK_LAST = 4'd15;

    state_t     state_q, state_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       rx_q, rx_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] samp_q, samp_d;
    logic       par_en_q, par_en_d;
    logic       par_odd_q, par_odd_d;
    logic       par_bit_q, par_bit_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    logic       w_rx_s;
    logic       w_vote;
    logic       w_tick;

    assign w_rx_s = sync2_q;
    assign w_tick = baud_tick_x16_i;
    // Third sample is the live synchronised line at the vote tick.
    assign w_vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & w_rx_s) | (samp_q[1] & w_rx_s);

    always_comb begin
        state_d    = state_q;
        sync1_d    = rx_i;
        sync2_d    = sync1_q;
        rx_d       = sync2_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        par_bit_d  = par_bit_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;

        if (!rx_en_i) begin
            state_d    = ST_IDLE;
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
        end else begin
            if (w_tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == C_TICK_S0) samp_d[0] = w_rx_s;
                if (tick_cnt_q == C_TICK_S1) samp_d[1] = w_rx_s;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_q && !w_rx_s) begin
                        state_d    = ST_START;
                        tick_cnt_d = 4'd0;
                        par_en_d   = parity_en_i;
                        par_odd_d  = parity_odd_i;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (tick_cnt_q == C_TICK_VOTE && w_vote) begin
                            state_d = ST_IDLE;
                        end else if (tick_cnt_q == C_TICK_LAST) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (tick_cnt_q == C_TICK_VOTE) begin
                            shift_d = {w_vote, shift_q[7:1]};
                        end else if (tick_cnt_q == C_TICK_LAST) begin
                            if (bit_cnt_q == 3'd7) begin
                                state_d = par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        if (tick_cnt_q == C_TICK_VOTE) begin
                            par_bit_d = w_vote;
                        end else if (tick_cnt_q == C_TICK_LAST) begin
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    // Commit mid-stop-bit so the next start edge can be caught early.
                    if (w_tick && tick_cnt_q == C_TICK_VOTE) begin
                        data_d  = shift_q;
                        ferr_d  = ~w_vote;
                        perr_d  = par_en_q ? (par_bit_q ^ (^shift_q) ^ par_odd_q) : 1'b0;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_q       <= 1'b1;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            samp_q     <= 2'b00;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            rx_q       <= rx_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            par_bit_q  <= par_bit_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;

endmodule
`default_nettype wire

// File: doc/uart_rx_os16.md
# uart_rx_os16

UART receive stage with 16x oversampling, the receive-side counterpart of the transmitter inside the `uart` top. It consumes `baud_tick_x16` from the top-level baud generator and the raw `rx_i` line, and deserialises 8N1 and 8E1/8O1 frames LSB-first. Each frame produces a byte with a one-cycle valid strobe plus parity and framing error flags. It drops into the `uart` top at the commented receive-instance position.

## Interface
- No parameters. Frame is fixed: 1 start bit, 8 data bits, optional parity bit, 1 stop bit.
- clk_i  in  1  single clock.
- rst_i  in  1  reset: asynchronous, active-high.
- baud_tick_x16_i  in  1  one-clk pulse at 16x the baud rate, from the top baud generator.
- rx_en_i  in  1  receiver enable. Low forces IDLE and aborts any frame in progress.
- parity_en_i  in  1  a parity bit follows the data bits.
- parity_odd_i  in  1  1 = odd parity, 0 = even.
- rx_i  in  1  asynchronous serial line, idle high.
- rx_data_o  out  8  last received byte. Holds until the next commit.
- rx_valid_o  out  1  one-clk pulse when rx_data_o and the error flags update.
- parity_err_o  out  1  parity mismatch on the last frame. Always 0 when parity was disabled.
- frame_err_o  out  1  stop bit sampled 0 on the last frame.

## Operation
- Synchroniser: 2 flops on rx_i, reset to 1, giving rx_s. A further flop rx_q (reset 1) provides edge detection.
- Tick counter tick_cnt: 4 bits, increments on every baud tick, wraps 15 -> 0. Cleared on start detect.
- Majority vote: samples of rx_s are captured on ticks where tick_cnt==7, 8 and 9. At tick_cnt==9 the bit value is the majority of the 3 samples.
- Bit counter: 3 bits. Shift register: 8 bits, filled LSB first (new bit enters at bit 7, register shifts right).
- States:
  - IDLE
    - Trigger: rx_en_i=1 and rx_q=1 and rx_s=0 (falling edge).
    - Actions: go to START; clear tick_cnt; latch parity_en_i and parity_odd_i for the whole frame.
    - A line held low never re-triggers without first returning high.
  - START
    - Vote at tick 9. Result 1 = false start: go to IDLE with no outputs changed.
    - At tick 15 go to DATA, bit_cnt=0.
  - DATA
    - Vote at tick 9 and shift the bit in.
    - At tick 15: if bit_cnt==7, go to PARITY when parity is latched, otherwise STOP. Else bit_cnt+1.
  - PARITY
    - Vote at tick 9 into par_bit. At tick 15 go to STOP.
  - STOP
    - Vote at tick 9, then commit and return to IDLE on that same tick. Returning mid-stop-bit allows resync to the next start edge.
    - Commit writes: rx_data_o = shift register; frame_err_o = ~stop_vote; rx_valid_o = 1 for one clk.
    - Commit parity: parity_err_o = par_bit ^ (^data) ^ parity_odd when parity is latched, else 0.
- rx_en_i low in any state: next clk go to IDLE and clear counters. No commit; outputs hold.
- Config changes mid-frame have no effect on that frame.

## Timing
- Reset values: rx_data_o=0x00, rx_valid_o=0, parity_err_o=0, frame_err_o=0. State IDLE, counters 0, synchroniser flops 1.
- Reset is asynchronous and takes effect mid-frame: no valid pulse is produced, and the partial byte is lost.
- Input latency: 2 clks synchroniser + 1 clk edge detect from the rx_i fall to the START transition.
- Commit point: rx_valid_o rises in the clk after the baud tick at STOP tick 9.
  - Without parity: 16 + 128 + 10 = 154 baud ticks after start detect.
  - With parity: 170 baud ticks after start detect.
- rx_valid_o lasts exactly 1 clk. rx_data_o and the error flags change only in that same cycle.
- A baud tick coinciding with rx_en_i falling: the abort wins.
- Minimum frame spacing: the next start edge may occur any time after commit, including before the nominal stop-bit end.

## Test plan
- Use bauds_lim=3 (one baud tick every 4 clks), 64 clks per bit.
- Send 0xA5 8N1 -> one rx_valid_o pulse, rx_data_o=0xA5, parity_err_o=0, frame_err_o=0.
- Send 0x3C with an even parity bit of 0, then 0x3C with an odd parity bit of 0 -> first frame parity_err_o=0, second frame parity_err_o=1; rx_data_o=0x3C both times.
- Send 0x55 with stop bit driven 0, then hold the line low 20 bit times and release -> one pulse with frame_err_o=1; no further pulses until a new falling edge.
- Low glitch of 16 clks on an idle line -> no rx_valid_o; the following legal 0x81 frame is received correctly.
- Two back-to-back frames 0x00 and 0xFF with no idle gap; then drop rx_en_i mid-data of a third frame -> exactly 2 pulses with the correct bytes; the third frame produces no pulse and rx_data_o stays 0xFF.
- Assert rst_i during bit 4 of a frame -> all outputs go to reset values immediately, no pulse; the next full frame 0x12 is received correctly.
